// File: rtl/ext_irq_pkg.sv
// ============================================================================
// Module      : ext_irq_pkg
// Description : Shared types, defaults and priority encoder for ext_irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ext_irq_pkg;

    localparam int c_N_IRQ_DEF = 31;
    localparam int c_ID_W_DEF  = 5;

    // Encoder works on a fixed 32-bit window; narrower masks are zero-extended.
    localparam int c_ENC_W    = 32;
    localparam int c_ENC_ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

    // Returns {valid, id}; lowest set index wins.
    function automatic logic [c_ENC_ID_W:0] prio_enc(input logic [c_ENC_W-1:0] mask);
        logic [c_ENC_ID_W:0] res;
        res = '0;
        for (int i = c_ENC_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res = {1'b1, c_ENC_ID_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-line multi-flop synchroniser with rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge #(
    parameter int N           = 31,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_ext,
    output logic [N-1:0] o_edge
);

    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [N-1:0]                  r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
// ============================================================================
// Module      : ext_irq_ctrl
// Description : External interrupt controller: pending/enable/priority + CPU handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int N_IRQ       = c_N_IRQ_DEF,
    parameter int ID_W        = c_ID_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_IRQ-1:0] i_ext,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    output logic [N_IRQ-1:0] en_q,
    output logic [N_IRQ-1:0] pend_q,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_eoi
);

    logic [N_IRQ-1:0]    w_edge;
    logic [N_IRQ-1:0]    w_clr;
    logic [c_ENC_ID_W:0] w_enc;
    logic                w_win_vld;
    logic [ID_W-1:0]     w_win_id;

    irq_state_t          r_state;
    irq_state_t          w_state_nxt;
    logic [N_IRQ-1:0]    r_pend;
    logic [N_IRQ-1:0]    r_en;
    logic                r_irq_req;
    logic                w_req_nxt;
    logic [ID_W-1:0]     r_irq_id;
    logic [ID_W-1:0]     w_id_nxt;
    logic                w_ack_clr;

    irq_sync_edge #(
        .N           (N_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (Clk),
        .rst    (Rst),
        .i_ext  (i_ext),
        .o_edge (w_edge)
    );

    assign w_enc     = prio_enc(c_ENC_W'(r_pend & r_en));
    assign w_win_vld = w_enc[c_ENC_ID_W];
    assign w_win_id  = ID_W'(w_enc[c_ENC_ID_W-1:0]);

    // Edge set is OR-ed in after the clear, so a coinciding edge keeps the bit.
    assign w_clr = w_ack_clr ? (N_IRQ'(1) << r_irq_id) : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_en      <= '0;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= (r_pend & ~w_clr) | w_edge;
            r_irq_req <= w_req_nxt;
            r_irq_id  <= w_id_nxt;
            if (en_we) begin
                r_en <= en_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_irq_req;
        w_id_nxt    = r_irq_id;
        w_ack_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_id_nxt    = w_win_id;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a same-cycle enable withdrawal.
                if (irq_ack) begin
                    w_state_nxt = ST_SVC;
                    w_req_nxt   = 1'b0;
                    w_ack_clr   = 1'b1;
                end else if (!r_en[r_irq_id]) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            ST_SVC: begin
                if (irq_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign en_q    = r_en;
    assign pend_q  = r_pend;
    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

endmodule

`default_nettype wire

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
External interrupt controller that consumes the SoC's 31 external interrupt lines and presents one prioritised request to the CPU core.
- Each line is synchronised, rising-edge detected, latched as pending, masked by a software-written enable register, then priority-encoded.
- The CPU handshake is request/acknowledge/end-of-interrupt, with one interrupt in service at a time.
- Sits between the i_ext pins at SoC top level and the core's interrupt input.

Parameters:
N_IRQ, 31, number of external interrupt lines (i_ext width)
ID_W, 5, width of interrupt id; must satisfy 2**ID_W >= N_IRQ
SYNC_STAGES, 2, flip-flop synchroniser depth per line (>=2)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
i_ext  in  N_IRQ  external interrupt lines, asynchronous, active-high
en_we  in  1  write strobe for enable register
en_wdata  in  N_IRQ  new enable mask, captured when en_we=1
en_q  out  N_IRQ  current enable mask
pend_q  out  N_IRQ  current pending register
irq_req  out  1  interrupt request to core
irq_id  out  ID_W  index of requested/in-service line
irq_ack  in  1  core accepts request (single-cycle pulse)
irq_eoi  in  1  core finished handler (single-cycle pulse)

Behaviour:
- Reset: sync chains=0, edge-history=0, pend_q=0, en_q=0, irq_req=0, irq_id=0, state=IDLE.
- Input sampling:
  - Each i_ext bit passes through SYNC_STAGES flops.
  - Edge = sync_out & ~prev.
  - A source must hold a line high for at least one full Clk period; shorter pulses may be lost, and that is not an error of this block.
- Pending:
  - pend[i] is set on a detected edge, regardless of en[i]; a masked line stays pending.
  - pend[i] is cleared only by irq_ack while irq_id==i.
  - If set and clear coincide on the same bit, set wins and the bit stays 1.
- Enable: en_q <= en_wdata on en_we, effective next cycle. Disabling an in-service line does not abort service.
- Priority: lowest index of (pend_q & en_q) wins. The encoder is combinational on registered state.
- FSM:
  - IDLE: if any (pend_q & en_q) -> REQ. irq_id <= winner and irq_req <= 1, both registered. Latency from first synchronised edge to irq_req=1 is SYNC_STAGES+2 cycles.
  - REQ: irq_req=1, and irq_id is held stable while in REQ, even if a higher-priority line becomes pending.
    - On irq_ack -> SVC: irq_req <= 0 and pend[irq_id] cleared.
    - If the requested line's enable is cleared before ack: drop irq_req and return to IDLE without clearing pend.
  - SVC: irq_req=0, irq_id holds the in-service line. New edges keep accumulating in pend. On irq_eoi -> IDLE.
  - irq_eoi outside SVC and irq_ack outside REQ are ignored.
- Back-to-back: after eoi, the next request is asserted one cycle later (IDLE -> REQ).
- Rst asserted mid-operation: everything returns to reset values immediately (asynchronous). Pending edges are lost.

Decomposition:
- Package ext_irq_pkg: state enum (IDLE, REQ, SVC), N_IRQ/ID_W defaults.
- Function prio_enc(mask) -> {valid, id}, lowest index first.
- One sub-module, irq_sync_edge: N_IRQ-wide synchroniser plus rising-edge detector with async reset.
- FSM, pending, and enable logic stay in ext_irq_ctrl.

Test Plan:
1. Reset, en_we with 0x00000002, i_ext[1] high 2 cycles -> pend_q[1]=1; irq_req=1, irq_id=1 at SYNC_STAGES+2 cycles after the edge; irq_ack -> pend_q=0, irq_req=0; irq_eoi -> IDLE.
2. en_q=0, pulse i_ext[4] -> pend_q=0x10, irq_req stays 0; then en_we 0x10 -> irq_req=1, irq_id=4 two cycles later.
3. Enable all, pulse i_ext[7] and i_ext[3] on the same cycle -> irq_id=3 first; after ack+eoi -> irq_id=7; after ack -> pend_q=0.
4. In SVC for line 3, pulse i_ext[3] again -> pend_q[3]=1, irq_req=0 until irq_eoi, then irq_req=1 with irq_id=3.
5. Pulse i_ext[1] with width < 1 Clk between edges (4 ns at 10 ns period) -> no pend set (documented limitation); Rst asserted during REQ -> irq_req=0 and pend_q=0 combinationally, before the next edge.
6. In REQ on line 5, clear en[5] -> irq_req drops, pend_q[5] still 1, FSM back in IDLE; re-enable -> request reissued with irq_id=5.
